fifo_rr_drain_arb: RTL and testbench

//  Drains NUM_Q mem_fifo_buf instances onto one shared WIDTH-bit output stream.

---
 rtl/fifo_rr_drain_arb_if.sv | 26 ++
 rtl/fifo_rr_drain_arb.sv | 104 ++++++++++
 tb/tb_fifo_rr_drain_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_drain_arb_if.sv
// Bundle between the per-lane block buffers, the drain arbiter and the downstream encoder path.
// master = arbiter side, slave = buffers/downstream side.
interface fifo_rr_drain_arb_if #(
  parameter int WIDTH = 64,
  parameter int NUM_Q = 4
);
  localparam int QW = $clog2(NUM_Q);

  logic [NUM_Q-1:0]       q_empty;
  logic [NUM_Q*WIDTH-1:0] q_data;
  logic [NUM_Q-1:0]       q_rd;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [QW-1:0]          out_qid;

  modport master (
    input  q_empty, q_data, out_ready,
    output q_rd, out_valid, out_data, out_qid
  );

  modport slave (
    output q_empty, q_data, out_ready,
    input  q_rd, out_valid, out_data, out_qid
  );
endinterface

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain of NUM_Q block buffers onto one registered output stream, max BURST pops per grant.
// Optional ARB_Q0_PRIO_EN: queue 0 wins every arbitration point while it is non-empty.
module fifo_rr_drain_arb #(
  parameter int WIDTH = 64,
  parameter int NUM_Q = 4,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_rr_drain_arb_if.master  bus
);
  // state  | meaning
  // IDLE   | no queue held; next pop arbitrates from cur+1
  // LOCKED | queue cur holds the grant; cnt pops taken in this burst

  localparam int QW = $clog2(NUM_Q);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [QW-1:0]    cur;
  logic [CW-1:0]    cnt;
  logic             can_pop;
  logic             cont;
  logic             found;
  logic             pop;
  logic [QW-1:0]    sel;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    int            idx;
    logic [QW-1:0] idx_q;
    idx      = 0;
    idx_q    = '0;
    sel      = '0;
    found    = 1'b0;
    sel_data = '0;
    bus.q_rd = '0;
    can_pop  = !bus.out_valid || bus.out_ready;
    cont     = (state == LOCKED) && !bus.q_empty[cur] && (cnt < CW'(BURST));
    if (cont) begin
      sel   = cur;
      found = 1'b1;
    end
`ifdef ARB_Q0_PRIO_EN
    else if (!bus.q_empty[0]) begin
      sel   = '0;
      found = 1'b1;
    end
`endif
    else begin
      // scan backwards so the nearest queue after cur is the last (winning) assignment
      for (int k = NUM_Q; k >= 1; k--) begin
        idx   = (int'(cur) + k) % NUM_Q;
        idx_q = QW'(idx);
        if (!bus.q_empty[idx_q]) begin
          sel   = idx_q;
          found = 1'b1;
        end
      end
    end
    pop = can_pop && found && !reset;
    if (pop) bus.q_rd[sel] = 1'b1;
    for (int i = 0; i < NUM_Q; i++) begin
      if (sel == QW'(i)) sel_data = bus.q_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    if (pop)                   state_nxt = LOCKED;
    else if (can_pop && !found) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_qid   <= '0;
      cnt           <= '0;
      cur           <= QW'(NUM_Q - 1);
    end else if (pop) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_qid   <= sel;
      if (cont) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= CW'(1);
        cur <= sel;
      end
    end else if (can_pop && !found) begin
      // cur kept so rotation resumes after the last served queue
      if (bus.out_ready) bus.out_valid <= 1'b0;
      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Bench for fifo_rr_drain_arb: buffer models feed the arbiter, expected words queued in grant order.
module tb_fifo_rr_drain_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_drain_arb_if #(.WIDTH(64), .NUM_Q(4)) bus ();

  fifo_rr_drain_arb #(.WIDTH(64), .NUM_Q(4), .BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  qid;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] mem [4][256];
  int          head [4];
  int          tail [4];
  int          total = 0;
  int          bad = 0;

  function automatic logic [63:0] mk(int q, int n);
    return {8'(q), 24'hC0FFEE, 32'(n)};
  endfunction

  task automatic sb_add(int q, int n);
    exp_t x;
    x.data = mk(q, n);
    x.qid  = 2'(q);
    sb.push_back(x);
  endtask

  task automatic push(int q, int n, bit exp_now);
    mem[q][tail[q]] = mk(q, n);
    tail[q] = tail[q] + 1;
    if (exp_now) sb_add(q, n);
  endtask

  // buffer model: registered empty, r_data is the head word
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.q_rd[i]) begin
        total++;
        if (head[i] >= tail[i]) begin
          bad++;
          $display("FAIL rd_on_empty: q%0d popped with head=%0d tail=%0d", i, head[i], tail[i]);
        end
        head[i] = head[i] + 1;
      end
      bus.q_empty[i] <= (head[i] >= tail[i]);
      bus.q_data[i*64 +: 64] <= mem[i][head[i]];
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    reset = 1'b1;
    push(1, 1, 1);
    repeat (2) @(negedge clk);
    total++;
    if (bus.q_rd !== 4'b0000) begin bad++; $display("FAIL rst_rd: got %b want 0000", bus.q_rd); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    total++;
    if (bus.out_data !== 64'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
    total++;
    if (bus.out_qid !== 2'd0) begin bad++; $display("FAIL rst_qid: got %0d want 0", bus.out_qid); end
    reset = 1'b0;
    for (int c = 0; c < 50 && sb.size() > 0; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front(); total++;
        if (bus.out_data !== e.data || bus.out_qid !== e.qid) begin
          bad++; $display("FAIL rst_word: got %h/q%0d want %h/q%0d", bus.out_data, bus.out_qid, e.data, e.qid);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL rst_timeout: %0d words left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_single_queue();
    logic [3:0] exp_rd;
    bus.out_ready = 1'b1;
    push(0, 10, 1); push(0, 11, 1); push(0, 12, 1);
    @(negedge clk);
    total++;
    if (bus.q_rd !== 4'b0001) begin bad++; $display("FAIL t1_rd_first: got %b want 0001", bus.q_rd); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_qid !== e.qid) begin
        bad++; $display("FAIL t1_word: got v%b %h/q%0d want v1 %h/q%0d", bus.out_valid, bus.out_data, bus.out_qid, e.data, e.qid);
      end
      exp_rd = (i < 2) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.q_rd !== exp_rd) begin bad++; $display("FAIL t1_rd: got %b want %b", bus.q_rd, exp_rd); end
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t1_valid_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    int  idle;
    bit  started;
    idle = 0; started = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int q = 0; q < 4; q++)
      for (int n = 0; n < 8; n++) push(q, 200 + n, 0);
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 4; q++)
        for (int k = 0; k < 4; k++) sb_add(q, 200 + r*4 + k);
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      if (bus.out_valid) started = 1;
      else if (started) idle++;
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front(); total++;
        if (bus.out_data !== e.data || bus.out_qid !== e.qid) begin
          bad++; $display("FAIL t2_word: got %h/q%0d want %h/q%0d", bus.out_data, bus.out_qid, e.data, e.qid);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL t2_timeout: %0d words left want 0", sb.size()); sb.delete(); end
    total++;
    if (idle != 0) begin bad++; $display("FAIL t2_idle: got %0d idle cycles want 0", idle); end
  endtask

  task automatic test_backpressure();
    int c;
    bus.out_ready = 1'b0;
    for (int n = 0; n < 6; n++) push(1, 300 + n, 1);
    c = 0;
    while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL t3_first_valid: got %b want 1", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.q_rd !== 4'b0000 || bus.out_data !== sb[0].data || bus.out_qid !== sb[0].qid) begin
        bad++; $display("FAIL t3_stall: got rd %b %h/q%0d want rd 0000 %h/q%0d", bus.q_rd, bus.out_data, bus.out_qid, sb[0].data, sb[0].qid);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.q_rd !== 4'b0010) begin bad++; $display("FAIL t3_resume_rd: got %b want 0010", bus.q_rd); end
    for (int k = 0; k < 60 && sb.size() > 0; k++) begin
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front(); total++;
        if (bus.out_data !== e.data || bus.out_qid !== e.qid) begin
          bad++; $display("FAIL t3_word: got %h/q%0d want %h/q%0d", bus.out_data, bus.out_qid, e.data, e.qid);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL t3_timeout: %0d words left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_burst_regrant();
    int  idle, pops;
    bit  started;
    idle = 0; pops = 0; started = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10; n++) push(2, 400 + n, 1);
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      if (bus.q_rd == 4'b0100) pops++;
      if (bus.out_valid) started = 1;
      else if (started) idle++;
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front(); total++;
        if (bus.out_data !== e.data || bus.out_qid !== e.qid) begin
          bad++; $display("FAIL t4_word: got %h/q%0d want %h/q%0d", bus.out_data, bus.out_qid, e.data, e.qid);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL t4_timeout: %0d words left want 0", sb.size()); sb.delete(); end
    total++;
    if (pops != 10) begin bad++; $display("FAIL t4_pops: got %0d want 10", pops); end
    total++;
    if (idle != 0) begin bad++; $display("FAIL t4_idle: got %0d idle cycles want 0", idle); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) push(2, 500 + n, 0);
    @(negedge clk);
    total++;
    if (bus.q_rd !== 4'b0100) begin bad++; $display("FAIL t5_rd_first: got %b want 0100", bus.q_rd); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mk(2, 500)) begin
      bad++; $display("FAIL t5_w0: got v%b %h want v1 %h", bus.out_valid, bus.out_data, mk(2, 500));
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mk(2, 501)) begin
      bad++; $display("FAIL t5_w1: got v%b %h want v1 %h", bus.out_valid, bus.out_data, mk(2, 501));
    end
    reset = 1'b1;
    push(0, 510, 1);
    push(1, 520, 1);
    for (int n = 2; n < 6; n++) sb_add(2, 500 + n);
    #1;
    total++;
    if (bus.q_rd !== 4'b0000) begin bad++; $display("FAIL t5_rd_in_reset: got %b want 0000", bus.q_rd); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.q_rd !== 4'b0000) begin
      bad++; $display("FAIL t5_after_reset: got v%b rd %b want v0 rd 0000", bus.out_valid, bus.q_rd);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.q_rd !== 4'b0001) begin bad++; $display("FAIL t5_first_grant: got %b want 0001", bus.q_rd); end
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front(); total++;
        if (bus.out_data !== e.data || bus.out_qid !== e.qid) begin
          bad++; $display("FAIL t5_word: got %h/q%0d want %h/q%0d", bus.out_data, bus.out_qid, e.data, e.qid);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL t5_timeout: %0d words left want 0", sb.size()); sb.delete(); end
  endtask

  // q1 mid-burst when q0 fills; q0 cuts ahead of q2 only when priority is built in
  task automatic test_q0_arrival();
    do_reset();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) push(1, 600 + n, 0);
    for (int n = 0; n < 2; n++) push(2, 610 + n, 0);
    for (int n = 0; n < 4; n++) sb_add(1, 600 + n);
`ifdef ARB_Q0_PRIO_EN
    sb_add(0, 620); sb_add(0, 621);
    sb_add(2, 610); sb_add(2, 611);
`else
    sb_add(2, 610); sb_add(2, 611);
    sb_add(0, 620); sb_add(0, 621);
`endif
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      if (c == 3) begin push(0, 620, 0); push(0, 621, 0); end
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front(); total++;
        if (bus.out_data !== e.data || bus.out_qid !== e.qid) begin
          bad++; $display("FAIL t6_word: got %h/q%0d want %h/q%0d", bus.out_data, bus.out_qid, e.data, e.qid);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL t6_timeout: %0d words left want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_queue();
    test_round_robin();
    test_backpressure();
    test_burst_regrant();
    test_reset_mid_burst();
    test_q0_arrival();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
